// File: rtl/sram_host_responder.sv
// ============================================================================
// Module   : sram_host_responder
// Summary  : Owns input SRAM + WMEM, serves DUT reads/writes, host preload,
//            start/done handshake and result readback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_host_responder #(
  parameter int DEPTH          = 4096,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_load_valid,
  output logic        host_load_ready,
  input  logic        host_load_sel,
  input  logic [11:0] host_load_addr,
  input  logic [15:0] host_load_data,
  input  logic        host_start,
  output logic        host_done,
  output logic        host_error,
  input  logic [11:0] host_rd_addr,
  output logic [15:0] host_rd_data,
  output logic [11:0] dut_write_count,
  output logic        dut_run,
  input  logic        dut_busy,
  input  logic [11:0] dut_sram_write_address,
  input  logic [15:0] dut_sram_write_data,
  input  logic        dut_sram_write_enable,
  input  logic [11:0] dut_sram_read_address,
  input  logic [11:0] dut_wmem_read_address,
  output logic [15:0] sram_dut_read_data,
  output logic [15:0] wmem_dut_read_data
);

  localparam int              c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              c_TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [12:0]     c_DEPTH = 13'(DEPTH);
  localparam logic [c_TW-1:0] c_TLAST = c_TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_BUSY = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_timeout;
  logic [c_TW-1:0] r_tcnt;
  logic            r_host_error;
  logic [11:0]     r_write_count;
  logic [15:0]     r_sram_rd;
  logic [15:0]     r_wmem_rd;
  logic [15:0]     r_host_rd;

  logic [15:0] r_sram [DEPTH];
  logic [15:0] r_wmem [DEPTH];

  // Address range qualifiers; out-of-range accesses never touch the arrays.
  logic w_load_in, w_dwr_in, w_drd_in, w_wrd_in, w_hrd_in;
  assign w_load_in = {1'b0, host_load_addr}         < c_DEPTH;
  assign w_dwr_in  = {1'b0, dut_sram_write_address} < c_DEPTH;
  assign w_drd_in  = {1'b0, dut_sram_read_address}  < c_DEPTH;
  assign w_wrd_in  = {1'b0, dut_wmem_read_address}  < c_DEPTH;
  assign w_hrd_in  = {1'b0, host_rd_addr}           < c_DEPTH;

  logic w_load_fire, w_dut_we, w_sram_load_we, w_wmem_load_we;
  assign w_load_fire    = (r_state == S_IDLE) && host_load_valid;
  assign w_sram_load_we = w_load_fire && !host_load_sel && w_load_in;
  assign w_wmem_load_we = w_load_fire &&  host_load_sel && w_load_in;
  assign w_dut_we       = ((r_state == S_RUN) || (r_state == S_BUSY)) &&
                          dut_sram_write_enable && w_dwr_in;

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: if (host_start) w_next = S_RUN;
      S_RUN: begin
        if (dut_busy) begin
          w_next = S_BUSY;
        end else if (r_tcnt == c_TLAST) begin
          w_next    = S_IDLE;
          w_timeout = 1'b1;
        end
      end
      S_BUSY: if (!dut_busy) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_tcnt        <= '0;
      r_host_error  <= 1'b0;
      r_write_count <= 12'd0;
    end else begin
      r_state      <= w_next;
      r_host_error <= w_timeout;
      r_tcnt       <= (r_state == S_RUN) ? r_tcnt + 1'b1 : '0;
      if ((r_state == S_IDLE) && host_start) begin
        r_write_count <= 12'd0;
      end else if (w_dut_we) begin
        r_write_count <= r_write_count + 12'd1;
      end
    end
  end

  // Arrays hold contents across reset; preload and DUT writes are state-exclusive.
  always_ff @(posedge clk) begin
    if (w_dut_we) begin
      r_sram[dut_sram_write_address[c_AW-1:0]] <= dut_sram_write_data;
    end else if (w_sram_load_we) begin
      r_sram[host_load_addr[c_AW-1:0]] <= host_load_data;
    end
    if (w_wmem_load_we) begin
      r_wmem[host_load_addr[c_AW-1:0]] <= host_load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sram_rd <= 16'd0;
      r_wmem_rd <= 16'd0;
      r_host_rd <= 16'd0;
    end else begin
      r_sram_rd <= w_drd_in ? r_sram[dut_sram_read_address[c_AW-1:0]] : 16'd0;
      r_wmem_rd <= w_wrd_in ? r_wmem[dut_wmem_read_address[c_AW-1:0]] : 16'd0;
      r_host_rd <= w_hrd_in ? r_sram[host_rd_addr[c_AW-1:0]]          : 16'd0;
    end
  end

  assign host_load_ready    = (r_state == S_IDLE);
  assign dut_run            = (r_state == S_RUN);
  assign host_done          = (r_state == S_DONE);
  assign host_error         = r_host_error;
  assign dut_write_count    = r_write_count;
  assign sram_dut_read_data = r_sram_rd;
  assign wmem_dut_read_data = r_wmem_rd;
  assign host_rd_data       = r_host_rd;

endmodule

`default_nettype wire

// File: tb/tb_sram_host_responder.sv
// ============================================================================
// Module   : tb_sram_host_responder
// Summary  : Directed self-checking bench for sram_host_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_host_responder;

  localparam int c_DEPTH   = 16;
  localparam int c_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_load_valid, host_load_ready, host_load_sel;
  logic [11:0] host_load_addr;
  logic [15:0] host_load_data;
  logic        host_start, host_done, host_error;
  logic [11:0] host_rd_addr;
  logic [15:0] host_rd_data;
  logic [11:0] dut_write_count;
  logic        dut_run, dut_busy;
  logic [11:0] dut_sram_write_address;
  logic [15:0] dut_sram_write_data;
  logic        dut_sram_write_enable;
  logic [11:0] dut_sram_read_address, dut_wmem_read_address;
  logic [15:0] sram_dut_read_data, wmem_dut_read_data;

  int n_cmp  = 0;
  int n_fail = 0;

  sram_host_responder #(.DEPTH(c_DEPTH), .TIMEOUT_CYCLES(c_TIMEOUT)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .host_load_valid        (host_load_valid),
    .host_load_ready        (host_load_ready),
    .host_load_sel          (host_load_sel),
    .host_load_addr         (host_load_addr),
    .host_load_data         (host_load_data),
    .host_start             (host_start),
    .host_done              (host_done),
    .host_error             (host_error),
    .host_rd_addr           (host_rd_addr),
    .host_rd_data           (host_rd_data),
    .dut_write_count        (dut_write_count),
    .dut_run                (dut_run),
    .dut_busy               (dut_busy),
    .dut_sram_write_address (dut_sram_write_address),
    .dut_sram_write_data    (dut_sram_write_data),
    .dut_sram_write_enable  (dut_sram_write_enable),
    .dut_sram_read_address  (dut_sram_read_address),
    .dut_wmem_read_address  (dut_wmem_read_address),
    .sram_dut_read_data     (sram_dut_read_data),
    .wmem_dut_read_data     (wmem_dut_read_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic sel, input logic [11:0] addr, input logic [15:0] data);
    host_load_valid = 1'b1;
    host_load_sel   = sel;
    host_load_addr  = addr;
    host_load_data  = data;
    check("load_ready", {31'd0, host_load_ready}, 32'd1);
    tick();
    host_load_valid = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    host_load_valid = 1'b0; host_load_sel = 1'b0; host_load_addr = '0; host_load_data = '0;
    host_start = 1'b0; host_rd_addr = '0; dut_busy = 1'b0;
    dut_sram_write_address = '0; dut_sram_write_data = '0; dut_sram_write_enable = 1'b0;
    dut_sram_read_address = '0; dut_wmem_read_address = '0;

    // Reset state
    tick(); tick();
    check("rst_run",   {31'd0, dut_run},    32'd0);
    check("rst_done",  {31'd0, host_done},  32'd0);
    check("rst_error", {31'd0, host_error}, 32'd0);
    check("rst_count", {20'd0, dut_write_count}, 32'd0);
    check("rst_srd",   {16'd0, sram_dut_read_data}, 32'd0);
    check("rst_hrd",   {16'd0, host_rd_data}, 32'd0);
    reset = 1'b0;
    tick();

    // Preload
    load(1'b0, 12'd0, 16'h0004);
    load(1'b0, 12'd1, 16'h0002);
    load(1'b0, 12'd2, 16'h1234);
    load(1'b0, 12'd3, 16'h5678);
    load(1'b0, 12'd5, 16'h0055);
    load(1'b0, 12'd6, 16'h0066);
    load(1'b1, 12'd0, 16'h00AA);
    load(1'b1, 12'd1, 16'h00BB);
    load(1'b0, 12'd20, 16'hDEAD);

    // DUT reads, 1-cycle latency
    dut_sram_read_address = 12'd2; dut_wmem_read_address = 12'd1; host_rd_addr = 12'd1;
    tick();
    check("rd_sram2", {16'd0, sram_dut_read_data}, 32'h1234);
    check("rd_wmem1", {16'd0, wmem_dut_read_data}, 32'h00BB);
    check("rd_host1", {16'd0, host_rd_data}, 32'h0002);
    dut_sram_read_address = 12'd3; dut_wmem_read_address = 12'd0;
    tick();
    check("rd_sram3", {16'd0, sram_dut_read_data}, 32'h5678);
    check("rd_wmem0", {16'd0, wmem_dut_read_data}, 32'h00AA);

    // Normal run: dut_run high 3 cycles
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    check("run_c1", {31'd0, dut_run}, 32'd1);
    check("start_count", {20'd0, dut_write_count}, 32'd0);
    tick();
    check("run_c2", {31'd0, dut_run}, 32'd1);
    tick();
    check("run_c3", {31'd0, dut_run}, 32'd1);
    dut_busy = 1'b1;
    tick();
    check("busy_run_low", {31'd0, dut_run}, 32'd0);

    // Read-first write during BUSY, blocked preload
    dut_sram_write_enable = 1'b1; dut_sram_write_address = 12'd5; dut_sram_write_data = 16'hBEEF;
    dut_sram_read_address = 12'd5;
    host_load_valid = 1'b1; host_load_sel = 1'b0; host_load_addr = 12'd0; host_load_data = 16'hFFFF;
    check("busy_ready", {31'd0, host_load_ready}, 32'd0);
    tick();
    host_load_valid = 1'b0;
    check("rf_old", {16'd0, sram_dut_read_data}, 32'h0055);
    check("count1", {20'd0, dut_write_count}, 32'd1);
    dut_sram_write_enable = 1'b0;
    tick();
    check("rf_new", {16'd0, sram_dut_read_data}, 32'hBEEF);

    // Out-of-range write and read
    dut_sram_write_enable = 1'b1; dut_sram_write_address = 12'd20; dut_sram_write_data = 16'h1111;
    dut_sram_read_address = 12'd20;
    tick();
    dut_sram_write_enable = 1'b0;
    check("oor_rd", {16'd0, sram_dut_read_data}, 32'd0);
    check("oor_count", {20'd0, dut_write_count}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("busy_no_done", {31'd0, host_done}, 32'd0);
    end
    dut_busy = 1'b0;
    tick();
    check("done_pulse", {31'd0, host_done}, 32'd1);
    check("done_run", {31'd0, dut_run}, 32'd0);
    tick();
    check("done_end", {31'd0, host_done}, 32'd0);
    check("idle_ready", {31'd0, host_load_ready}, 32'd1);
    host_rd_addr = 12'd5;
    tick();
    check("hrd5", {16'd0, host_rd_data}, 32'hBEEF);
    host_rd_addr = 12'd0;
    tick();
    check("hrd0_unchanged", {16'd0, host_rd_data}, 32'h0004);

    // DUT write in IDLE is ignored
    dut_sram_write_enable = 1'b1; dut_sram_write_address = 12'd6; dut_sram_write_data = 16'h7777;
    tick();
    dut_sram_write_enable = 1'b0;
    check("idle_wr_count", {20'd0, dut_write_count}, 32'd1);
    host_rd_addr = 12'd6;
    tick();
    check("idle_wr_mem", {16'd0, host_rd_data}, 32'h0066);

    // Timeout run
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    check("to_count_clr", {20'd0, dut_write_count}, 32'd0);
    n = 0;
    while (dut_run && n < 50) begin
      n++;
      tick();
    end
    check("to_run_cycles", n, c_TIMEOUT);
    check("to_error", {31'd0, host_error}, 32'd1);
    check("to_run_low", {31'd0, dut_run}, 32'd0);
    check("to_done", {31'd0, host_done}, 32'd0);
    tick();
    check("to_error_end", {31'd0, host_error}, 32'd0);
    check("to_count", {20'd0, dut_write_count}, 32'd0);

    // Reset mid-BUSY
    dut_sram_read_address = 12'd2; dut_wmem_read_address = 12'd1; host_rd_addr = 12'd5;
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    check("rst2_run", {31'd0, dut_run}, 32'd1);
    dut_busy = 1'b1;
    tick();
    check("rst2_busy_ready", {31'd0, host_load_ready}, 32'd0);
    check("rst2_srd_pre", {16'd0, sram_dut_read_data}, 32'h1234);
    #2 reset = 1'b1;
    #1;
    check("async_srd", {16'd0, sram_dut_read_data}, 32'd0);
    check("async_wrd", {16'd0, wmem_dut_read_data}, 32'd0);
    check("async_hrd", {16'd0, host_rd_data}, 32'd0);
    check("async_idle", {31'd0, host_load_ready}, 32'd1);
    check("async_run", {31'd0, dut_run}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    dut_busy = 1'b0;
    tick();
    check("keep_srd", {16'd0, sram_dut_read_data}, 32'h1234);
    check("keep_wrd", {16'd0, wmem_dut_read_data}, 32'h00BB);
    check("keep_hrd", {16'd0, host_rd_data}, 32'hBEEF);
    check("keep_run", {31'd0, dut_run}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
